wep_decrypt: RTL and testbench
==============================

# wep_decrypt

Receive-side counterpart of the WEP encryption engine. Reads an RC4-encrypted frame from the dual-port SRAM and regenerates the RC4 keystream from the 64-bit seed. Writes the recovered plaintext payload back to SRAM, then checks the trailing 4-byte ICV against a CRC-32 computed over that payload. Sits on port A of the shared DPSRAM, beside the encryptor, under the same host control logic.

## Interface
Parameters:
- `MAX_FRAME`, default 65532: largest legal `frame_size` in bytes; larger values are treated as errors.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `start_decrypt`  in  1  level; sampled in IDLE only.
- `cipher_addr`  in  32  word address of the ciphertext; bits [15:0] used.
- `plain_addr`  in  32  word address for the plaintext output; bits [15:0] used.
- `frame_size`  in  32  ciphertext length in bytes, including the 4-byte ICV.
- `seed_msw`, `seed_lsw`  in  32 each  seed bytes: seed[0..3] = `seed_lsw`[7:0..31:24]; seed[4..7] = `seed_msw`[7:0..31:24].
- `port_A_data_out`  in  32  SRAM read data.
- `port_A_data_in`  out  32  SRAM write data.
- `port_A_addr`  out  16  SRAM word address.
- `port_A_we`  out  1  SRAM write enable.
- `port_A_clk`  out  1  equals `clk`.
- `done`  out  1  one-cycle completion pulse.
- `icv_ok`  out  1  ICV result; valid from `done` until the next accepted start.

## Operation
- Reset values: `done`=0, `icv_ok`=0, `port_A_we`=0, `port_A_addr`=0, `port_A_data_in`=0. State returns to IDLE. A reset mid-frame aborts the frame; partial writes are left in SRAM.
- IDLE: S[k]=k for all k, i=0, j=0. On `start_decrypt`=1, latch all address, size and seed inputs, then go to KSA. While busy, `start_decrypt` is ignored.
- Size check before KSA: if `frame_size` < 4 or > `MAX_FRAME`, go straight to DONE with `icv_ok`=0 and perform no SRAM writes.
- KSA: for i = 0..255, j = j + S[i] + seed[i mod 8] (mod 256), then swap S[i] and S[j]. All arithmetic is 8-bit wrap.
- PRGA init: i=0, j=0.
- Each byte: i = i+1, j = j+S[i], swap, K = S[S[i]+S[j]], P = C xor K.
- Byte b of the frame is lane b mod 4 (little-endian) of word `cipher_addr` + b/4.
- Bytes b < N-4 (payload): feed P to the CRC and store P into the output word.
- Bytes b >= N-4 (ICV): shift P into `rx_icv`, LSB first. The ICV may straddle a word boundary.
- Output words go to `plain_addr` + b/4. A word is written when its 4 lanes are filled or the payload ends. Unused lanes of the final word are written as 0. The ICV is never written.
- CRC-32: reflected poly 0xEDB88320, init 0xFFFFFFFF, final complement. Empty payload gives 0x00000000.
- CHECK: `icv_ok` = (crc_final == `rx_icv`).
- States: IDLE -> KSA_J -> KSA_SWAP (loop 256×) -> RD_ADDR -> RD_DATA -> PRGA_STEP -> XOR (loop per lane) -> WR -> RD_ADDR | CHECK -> DONE -> IDLE.

## Timing
- SRAM is synchronous with 1-cycle read latency: data for an address driven in cycle t is valid in cycle t+1.
- `port_A_we` is high for exactly one cycle per output word. Reads and writes never overlap.
- KSA takes exactly 512 cycles (2 per index).
- PRGA: 2 cycles per byte, plus 2 cycles per word read and 1 cycle per word written.
- Total latency from start to `done` must be ≤ 515 + 5·ceil(N/4) + 2N cycles.
- `done` is high for one cycle in DONE, and `icv_ok` is updated in that same cycle.
- The next start is accepted the cycle after DONE. The S-box is re-initialised in IDLE during that one cycle.

## Structure
- Package `wep_pkg`:
  - state enum;
  - `CRC32_POLY`, `CRC32_INIT`;
  - `ICV_BYTES`=4;
  - seed byte-unpack function.
- Sub-module `wep_crc32`: byte-serial CRC with `clr`, `en`, `byte_in` and `crc_out` (complemented result), one byte per cycle. Shared with a future ICV-generating encryptor.
- S-box: 256×8 register array. The top level owns the FSM, i/j, lane counter and `rx_icv`.

## Test plan
- Round trip: seed_lsw=0x03020100, seed_msw=0x07060504, 12-byte payload "WEP decrypt!", ICV appended, encrypted by the software model, N=16 -> 3 plaintext words match byte-for-byte and `icv_ok`=1.
- Bit flip: same frame with ciphertext byte 5 xor 0x01 -> plaintext differs only in byte 5 and `icv_ok`=0.
- Unaligned: N=11 (7-byte payload, ICV straddles words 1–2) -> 2 words written, lane 3 of word 1 = 0x00, `icv_ok`=1.
- Empty payload: N=4 with ICV encrypted as 0x00000000 -> no writes and `icv_ok`=1.
- Illegal size: N=3 -> `done` within 3 cycles, `icv_ok`=0, `port_A_we` never high.
- Reset abort: assert `reset` at KSA index 100 -> all outputs are at reset values the same cycle; a restarted frame decrypts correctly.

Source files
------------

// File: rtl/wep_pkg.sv
// Shared types and constants for the WEP receive path: FSM states, CRC-32
// parameters and seed byte extraction.
package wep_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_KSA_J,
        ST_KSA_SWAP,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_PRGA_STEP,
        ST_XOR,
        ST_WR,
        ST_CHECK,
        ST_DONE
    } state_e;

    localparam logic [31:0] CRC32_POLY = 32'hEDB8_8320;
    localparam logic [31:0] CRC32_INIT = 32'hFFFF_FFFF;
    localparam int          ICV_BYTES  = 4;

    // seed = {seed_msw, seed_lsw}; byte 0 is seed_lsw[7:0].
    function automatic logic [7:0] seed_byte(input logic [63:0] seed, input logic [2:0] idx);
        return seed[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/wep_crc32.sv
// Byte-serial reflected CRC-32. crc_out is the complemented running value, so
// it reads as the finished CRC after the last byte has been absorbed.
module wep_crc32
    import wep_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  byte_in,
    output logic [31:0] crc_out
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;

    always_comb begin
        crc_d = crc_q ^ {24'h0, byte_in};
        for (int k = 0; k < 8; k++) begin
            crc_d = crc_d[0] ? ((crc_d >> 1) ^ CRC32_POLY) : (crc_d >> 1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crc_q <= CRC32_INIT;
        end else if (clr) begin
            crc_q <= CRC32_INIT;
        end else if (en) begin
            crc_q <= crc_d;
        end
    end

    assign crc_out = ~crc_q;

endmodule

// File: rtl/wep_decrypt.sv
// RC4 decryptor on SRAM port A: regenerates the keystream, writes the
// recovered payload back word by word and checks the trailing CRC-32 ICV.
module wep_decrypt
    import wep_pkg::*;
#(
    parameter int unsigned MAX_FRAME = 65532
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_decrypt,
    input  logic [31:0] cipher_addr,
    input  logic [31:0] plain_addr,
    input  logic [31:0] frame_size,
    input  logic [31:0] seed_msw,
    input  logic [31:0] seed_lsw,
    input  logic [31:0] port_A_data_out,
    output logic [31:0] port_A_data_in,
    output logic [15:0] port_A_addr,
    output logic        port_A_we,
    output logic        port_A_clk,
    output logic        done,
    output logic        icv_ok
);

    state_e      state_q;
    logic [7:0]  sbox_q [256];
    logic [7:0]  i_q, j_q;
    logic [15:0] b_q, n_q, pl_q;
    logic [15:0] caddr_q, paddr_q;
    logic [63:0] seed_q;
    logic [31:0] cw_q, ow_q, rx_icv_q;
    logic        fresh_q;
    logic        done_q, icv_ok_q, we_q;
    logic [15:0] addr_q;
    logic [31:0] wdata_q;

    logic [7:0]  ni, nj, ksa_j, kidx, ks, pbyte;
    logic [1:0]  lane;
    logic        is_pay, last_pay, crc_en, crc_clr;
    logic [15:0] bx;
    logic [31:0] ow_ins, crc_out;
    state_e      cont_st;
    logic        unused_addr_hi;

    assign unused_addr_hi = ^{cipher_addr[31:16], plain_addr[31:16]};

    always_comb begin
        ni       = i_q + 8'd1;
        nj       = j_q + sbox_q[ni];
        ksa_j    = j_q + sbox_q[i_q] + seed_byte(seed_q, i_q[2:0]);
        kidx     = sbox_q[i_q] + sbox_q[j_q];
        ks       = sbox_q[kidx];
        lane     = b_q[1:0];
        pbyte    = cw_q[{lane, 3'b000} +: 8] ^ ks;
        is_pay   = b_q < pl_q;
        last_pay = (b_q == pl_q - 16'd1);
        ow_ins   = ow_q;
        ow_ins[{lane, 3'b000} +: 8] = pbyte;
        // Where to go once the current byte (and any write it triggered) is finished.
        bx = (state_q == ST_XOR) ? b_q + 16'd1 : b_q;
        if (bx == n_q) begin
            cont_st = ST_CHECK;
        end else if (bx[1:0] == 2'd0) begin
            cont_st = ST_RD_ADDR;
        end else begin
            cont_st = ST_PRGA_STEP;
        end
    end

    assign crc_clr = (state_q == ST_IDLE) && start_decrypt;
    assign crc_en  = (state_q == ST_XOR) && is_pay;

    wep_crc32 u_crc (
        .clk     (clk),
        .reset   (reset),
        .clr     (crc_clr),
        .en      (crc_en),
        .byte_in (pbyte),
        .crc_out (crc_out)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            for (int k = 0; k < 256; k++) sbox_q[k] <= 8'(k);
            i_q      <= '0;
            j_q      <= '0;
            b_q      <= '0;
            n_q      <= '0;
            pl_q     <= '0;
            caddr_q  <= '0;
            paddr_q  <= '0;
            seed_q   <= '0;
            cw_q     <= '0;
            ow_q     <= '0;
            rx_icv_q <= '0;
            fresh_q  <= 1'b0;
            done_q   <= 1'b0;
            icv_ok_q <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    for (int k = 0; k < 256; k++) sbox_q[k] <= 8'(k);
                    i_q <= '0;
                    j_q <= '0;
                    if (start_decrypt) begin
                        caddr_q  <= cipher_addr[15:0];
                        paddr_q  <= plain_addr[15:0];
                        n_q      <= frame_size[15:0];
                        pl_q     <= frame_size[15:0] - 16'(ICV_BYTES);
                        seed_q   <= {seed_msw, seed_lsw};
                        b_q      <= '0;
                        ow_q     <= '0;
                        rx_icv_q <= '0;
                        icv_ok_q <= 1'b0;
                        if (frame_size < 32'(ICV_BYTES) || frame_size > MAX_FRAME) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_KSA_J;
                        end
                    end
                end
                ST_KSA_J: begin
                    j_q     <= ksa_j;
                    state_q <= ST_KSA_SWAP;
                end
                ST_KSA_SWAP: begin
                    sbox_q[i_q] <= sbox_q[j_q];
                    sbox_q[j_q] <= sbox_q[i_q];
                    i_q         <= ni;
                    if (i_q == 8'd255) begin
                        j_q     <= '0;
                        state_q <= ST_RD_ADDR;
                    end else begin
                        state_q <= ST_KSA_J;
                    end
                end
                ST_RD_ADDR: begin
                    addr_q  <= caddr_q + b_q[15:2];
                    state_q <= ST_RD_DATA;
                end
                ST_RD_DATA: begin
                    fresh_q <= 1'b1;
                    state_q <= ST_PRGA_STEP;
                end
                ST_PRGA_STEP: begin
                    // Read data for the address issued in RD_ADDR lands this cycle.
                    if (fresh_q) begin
                        cw_q    <= port_A_data_out;
                        fresh_q <= 1'b0;
                    end
                    i_q        <= ni;
                    j_q        <= nj;
                    sbox_q[ni] <= sbox_q[nj];
                    sbox_q[nj] <= sbox_q[ni];
                    state_q    <= ST_XOR;
                end
                ST_XOR: begin
                    b_q <= b_q + 16'd1;
                    if (is_pay) begin
                        if (lane == 2'd3 || last_pay) begin
                            we_q    <= 1'b1;
                            addr_q  <= paddr_q + b_q[15:2];
                            wdata_q <= ow_ins;
                            ow_q    <= '0;
                            state_q <= ST_WR;
                        end else begin
                            ow_q    <= ow_ins;
                            state_q <= cont_st;
                        end
                    end else begin
                        rx_icv_q <= {pbyte, rx_icv_q[31:8]};
                        state_q  <= cont_st;
                    end
                end
                ST_WR: begin
                    state_q <= cont_st;
                end
                ST_CHECK: begin
                    icv_ok_q <= (crc_out == rx_icv_q);
                    done_q   <= 1'b1;
                    state_q  <= ST_DONE;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign port_A_data_in = wdata_q;
    assign port_A_addr    = addr_q;
    assign port_A_we      = we_q;
    assign port_A_clk     = clk;
    assign done           = done_q;
    assign icv_ok         = icv_ok_q;

endmodule

// File: tb/tb_wep_decrypt.sv
// Scoreboard bench for wep_decrypt: a software RC4/CRC-32 model builds
// encrypted frames, predicts SRAM writes and the ICV verdict.
module tb_wep_decrypt;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_decrypt = 1'b0;
    logic [31:0] cipher_addr = '0, plain_addr = '0, frame_size = '0;
    logic [31:0] seed_msw = '0, seed_lsw = '0, rdata = '0;
    logic [31:0] port_A_data_in;
    logic [15:0] port_A_addr;
    logic        port_A_we, port_A_clk, done, icv_ok;

    always #5 clk = ~clk;

    wep_decrypt dut (
        .clk             (clk),
        .reset           (reset),
        .start_decrypt   (start_decrypt),
        .cipher_addr     (cipher_addr),
        .plain_addr      (plain_addr),
        .frame_size      (frame_size),
        .seed_msw        (seed_msw),
        .seed_lsw        (seed_lsw),
        .port_A_data_out (rdata),
        .port_A_data_in  (port_A_data_in),
        .port_A_addr     (port_A_addr),
        .port_A_we       (port_A_we),
        .port_A_clk      (port_A_clk),
        .done            (done),
        .icv_ok          (icv_ok)
    );

    logic [31:0] mem [0:65535];
    always @(posedge clk) rdata <= mem[port_A_addr];

    typedef logic [7:0] bytes_t[$];
    typedef struct packed { logic [15:0] addr; logic [31:0] data; } wr_t;

    wr_t    exp_wr[$];
    logic   exp_icv[$];
    bytes_t pay_m, ks_m;
    int     n_cmp = 0, n_fail = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Plain RC4 keystream of n bytes for a 64-bit seed.
    task automatic gen_ks(input logic [63:0] seed, input int n);
        int s[256];
        int i, j, t;
        ks_m.delete();
        for (int k = 0; k < 256; k++) s[k] = k;
        j = 0;
        for (int k = 0; k < 256; k++) begin
            j = (j + s[k] + int'((seed >> (8 * (k % 8))) & 64'hFF)) % 256;
            t = s[k]; s[k] = s[j]; s[j] = t;
        end
        i = 0; j = 0;
        for (int k = 0; k < n; k++) begin
            i = (i + 1) % 256;
            j = (j + s[i]) % 256;
            t = s[i]; s[i] = s[j]; s[j] = t;
            ks_m.push_back(8'(s[(s[i] + s[j]) % 256]));
        end
    endtask

    function automatic logic [31:0] crc32_of(input bytes_t d);
        logic [31:0] c = 32'hFFFF_FFFF;
        foreach (d[k]) begin
            c ^= {24'h0, d[k]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    // Pulse start, wait for done within a bounded number of cycles.
    task automatic do_start(input int bound);
        int lat;
        start_decrypt = 1'b1;
        @(negedge clk);
        lat = 1;
        start_decrypt = 1'b0;
        while (!done && lat < bound + 50) begin
            @(negedge clk);
            lat++;
        end
        n_cmp++;
        if (!done || lat > bound) begin
            n_fail++;
            $display("FAIL latency: got %0d cycles (done=%0b) limit %0d", lat, done, bound);
        end
        check("writes_drained", 64'(exp_wr.size()), 64'd0);
        @(negedge clk);
    endtask

    // Encrypt pay_m (+ICV) into SRAM, predict the DUT response, run it.
    task automatic run_frame(input logic [15:0] ca, input logic [15:0] pa, input logic [63:0] seed,
                             input int flip_idx, input logic [7:0] flip_mask, input bit bad_icv);
        bytes_t fr, dec, dp;
        logic [31:0] icv, icv_rx, w;
        logic [7:0]  c;
        logic [15:0] a;
        int n, p, b;
        fr  = pay_m;
        icv = crc32_of(pay_m);
        if (bad_icv) icv ^= 32'h0000_0100;
        for (int k = 0; k < 4; k++) fr.push_back(icv[8 * k +: 8]);
        n = fr.size();
        p = n - 4;
        gen_ks(seed, n);
        for (int wi = 0; wi < (n + 3) / 4; wi++) begin
            w = $urandom();
            for (int l = 0; l < 4; l++) begin
                b = 4 * wi + l;
                if (b < n) begin
                    c = fr[b] ^ ks_m[b];
                    if (b == flip_idx) c ^= flip_mask;
                    w[8 * l +: 8] = c;
                    dec.push_back(c ^ ks_m[b]);
                end
            end
            a = ca + 16'(wi);
            mem[a] = w;
        end
        for (int k = 0; k < p; k++) dp.push_back(dec[k]);
        icv_rx = {dec[n - 1], dec[n - 2], dec[n - 3], dec[n - 4]};
        for (int wi = 0; wi < (p + 3) / 4; wi++) begin
            w = '0;
            for (int l = 0; l < 4; l++) if (4 * wi + l < p) w[8 * l +: 8] = dec[4 * wi + l];
            exp_wr.push_back('{addr: pa + 16'(wi), data: w});
        end
        exp_icv.push_back(crc32_of(dp) == icv_rx);
        cipher_addr = ($urandom() << 16) | 32'(ca);
        plain_addr  = ($urandom() << 16) | 32'(pa);
        frame_size  = 32'(n);
        seed_msw    = seed[63:32];
        seed_lsw    = seed[31:0];
        do_start(515 + 5 * ((n + 3) / 4) + 2 * n);
    endtask

    task automatic run_bad(input logic [31:0] size);
        exp_icv.push_back(1'b0);
        frame_size = size;
        do_start(3);
    endtask

    task automatic load_str(input string s);
        pay_m.delete();
        for (int k = 0; k < s.len(); k++) pay_m.push_back(s[k]);
    endtask

    // Monitor: consumes expected writes and verdicts as the DUT presents them.
    wr_t mon_e;
    always @(negedge clk) begin
        if (!reset && port_A_we) begin
            if (exp_wr.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL unexpected_write: addr %h data %h, none expected", port_A_addr, port_A_data_in);
            end else begin
                mon_e = exp_wr.pop_front();
                check("wr_addr", 64'(port_A_addr), 64'(mon_e.addr));
                check("wr_data", 64'(port_A_data_in), 64'(mon_e.data));
            end
        end
        if (!reset && done) begin
            if (exp_icv.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL unexpected_done: icv_ok %0b, no frame pending", icv_ok);
            end else begin
                check("icv_ok", 64'(icv_ok), 64'(exp_icv.pop_front()));
            end
        end
    end

    localparam logic [63:0] SEED_TP = 64'h0706_0504_0302_0100;

    initial begin
        logic [63:0] sd;
        int len, fi;
        repeat (3) @(negedge clk);
        check("rst_done", 64'(done), 64'd0);
        check("rst_icv_ok", 64'(icv_ok), 64'd0);
        check("rst_we", 64'(port_A_we), 64'd0);
        check("rst_addr", 64'(port_A_addr), 64'd0);
        check("rst_wdata", 64'(port_A_data_in), 64'd0);
        check("port_A_clk", 64'(port_A_clk), 64'(clk));
        reset = 1'b0;
        @(negedge clk);

        load_str("WEP decrypt!");
        run_frame(16'h0100, 16'h2000, SEED_TP, -1, 8'h00, 1'b0);
        run_frame(16'h0100, 16'h2000, SEED_TP, 5, 8'h01, 1'b0);
        load_str("unalign");
        run_frame(16'h0300, 16'h2100, SEED_TP, -1, 8'h00, 1'b0);
        pay_m.delete();
        run_frame(16'h0400, 16'h2200, SEED_TP, -1, 8'h00, 1'b0);

        run_bad(32'd3);
        run_bad(32'd0);
        run_bad(32'd65533);

        // Abort mid-KSA: outputs must clear as soon as reset rises.
        load_str("WEP decrypt!");
        frame_size = 32'd16;
        start_decrypt = 1'b1;
        @(negedge clk);
        start_decrypt = 1'b0;
        repeat (200) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_done", 64'(done), 64'd0);
        check("abort_icv_ok", 64'(icv_ok), 64'd0);
        check("abort_we", 64'(port_A_we), 64'd0);
        check("abort_addr", 64'(port_A_addr), 64'd0);
        check("abort_wdata", 64'(port_A_data_in), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_frame(16'h0100, 16'h2000, SEED_TP, -1, 8'h00, 1'b0);

        for (int r = 0; r < 6; r++) begin
            sd  = {$urandom(), $urandom()};
            len = $urandom_range(0, 25);
            pay_m.delete();
            for (int k = 0; k < len; k++) pay_m.push_back(8'($urandom()));
            fi = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len + 3) : -1;
            run_frame(16'($urandom()), 16'($urandom()), sd, fi, 8'(1 << $urandom_range(0, 7)),
                      $urandom_range(0, 3) == 0);
        end

        check("icv_queue_empty", 64'(exp_icv.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
        $finish;
    end

endmodule
